// File: rtl/l3_uart_tx.sv
// Layer-3 result drain: pops 18-bit signed words from the pooled buffer and sends
// each as three 8N1 UART bytes (LSB byte first, top byte sign-extended).
module l3_uart_tx #(
    parameter int BAUD_DIV  = 434,
    parameter int NUM_WORDS = 98
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [17:0] din,
    output logic        pop,
    output logic        TX,
    output logic        bsy,
    output logic        tx_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [6:0]    WORD_LAST = 7'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [17:0]     word_r, word_s;
    logic [7:0]      shift_r, shift_s;
    logic [1:0]      byte_idx_r, byte_idx_s;
    logic [BW-1:0]   baud_cnt_r, baud_cnt_s;
    logic [2:0]      bit_cnt_r, bit_cnt_s;
    logic [6:0]      word_cnt_r, word_cnt_s;
    logic            tx_done_r, tx_done_s;
    logic            tx_r, tx_s;
    logic            bsy_r, bsy_s;
    logic            pop_s;
    logic            baud_end_s;

    // Byte j of the outgoing word; the top byte carries the sign of bit 17.
    function automatic logic [7:0] byte_sel(input logic [17:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            default: b = {{6{word[17]}}, word[17:16]};
        endcase
        return b;
    endfunction

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            word_r     <= 18'd0;
            shift_r    <= 8'd0;
            byte_idx_r <= 2'd0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            word_cnt_r <= 7'd0;
            tx_done_r  <= 1'b0;
            tx_r       <= 1'b1;
            bsy_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            word_r     <= word_s;
            shift_r    <= shift_s;
            byte_idx_r <= byte_idx_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            word_cnt_r <= word_cnt_s;
            tx_done_r  <= tx_done_s;
            tx_r       <= tx_s;
            bsy_r      <= bsy_s;
        end
    end

    // Pop acknowledge; held off during the tx_done cycle while the producer clears.
    always_comb begin
        pop_s = 1'b0;
        if (rst_n && (state_r == ST_IDLE) && rdy && !tx_done_r) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_s    = state_r;
        word_s     = word_r;
        shift_s    = shift_r;
        byte_idx_s = byte_idx_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        word_cnt_s = word_cnt_r;
        tx_done_s  = 1'b0;
        baud_end_s = (baud_cnt_r == BAUD_LAST);
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    word_s     = din;
                    shift_s    = byte_sel(din, 2'd0);
                    byte_idx_s = 2'd0;
                    baud_cnt_s = '0;
                    state_s    = ST_START;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_cnt_s = '0;
                    bit_cnt_s  = 3'd0;
                    state_s    = ST_DATA;
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_cnt_s = '0;
                    shift_s    = {1'b0, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_cnt_s = '0;
                    if (byte_idx_r < 2'd2) begin
                        // Back-to-back bytes: next start bit follows the stop bit directly.
                        byte_idx_s = byte_idx_r + 2'd1;
                        shift_s    = byte_sel(word_r, byte_idx_r + 2'd1);
                        state_s    = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                        if (word_cnt_r == WORD_LAST) begin
                            word_cnt_s = 7'd0;
                            tx_done_s  = 1'b1;
                        end else begin
                            word_cnt_s = word_cnt_r + 7'd1;
                        end
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered line and busy values, decoded from the upcoming state.
    always_comb begin
        tx_s  = 1'b1;
        bsy_s = 1'b0;
        case (state_s)
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
        if (state_s != ST_IDLE) begin
            bsy_s = 1'b1;
        end else begin
            bsy_s = 1'b0;
        end
    end

    assign pop     = pop_s;
    assign TX      = tx_r;
    assign bsy     = bsy_r;
    assign tx_done = tx_done_r;

endmodule

// File: tb/tb_l3_uart_tx.sv
// Bench for l3_uart_tx: two instances (BAUD_DIV=4/NUM_WORDS=3 and BAUD_DIV=2/NUM_WORDS=1)
// checked cycle by cycle against an ideal 8N1 frame built from each popped word.
module tb_l3_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_v;
    logic [17:0] din_v;
    int          sel;

    logic rdy_a, rdy_b, pop_a, pop_b, tx_a, tx_b, bsy_a, bsy_b, done_a, done_b;
    logic pop_m, tx_m, bsy_m, done_m;

    int checks = 0;
    int failures = 0;
    int cycle_n = 0;
    int words[2];
    int last_pop = -1;
    int pop_gap = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle_n <= cycle_n + 1;

    assign rdy_a  = (sel == 0) ? rdy_v : 1'b0;
    assign rdy_b  = (sel != 0) ? rdy_v : 1'b0;
    assign pop_m  = (sel != 0) ? pop_b  : pop_a;
    assign tx_m   = (sel != 0) ? tx_b   : tx_a;
    assign bsy_m  = (sel != 0) ? bsy_b  : bsy_a;
    assign done_m = (sel != 0) ? done_b : done_a;

    l3_uart_tx #(.BAUD_DIV(4), .NUM_WORDS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .rdy(rdy_a), .din(din_v),
        .pop(pop_a), .TX(tx_a), .bsy(bsy_a), .tx_done(done_a));

    l3_uart_tx #(.BAUD_DIV(2), .NUM_WORDS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rdy(rdy_b), .din(din_v),
        .pop(pop_b), .TX(tx_b), .bsy(bsy_b), .tx_done(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int ncyc);
        rst_n = 1'b0;
        rdy_v = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            #1;
            chk("pop_in_reset", pop_m, 1'b0);
            cyc();
        end
        rst_n = 1'b1;
        rdy_v = 1'b0;
        words[0] = 0;
        words[1] = 0;
        #1;
        chk("rst_tx", tx_m, 1'b1);
        chk("rst_bsy", bsy_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
    endtask

    // Waits for a pop of w (bounded) and returns in the first cycle after the pop edge.
    task automatic start_word(input logic [17:0] w, input bit hold);
        int waited;
        din_v = w;
        rdy_v = 1'b1;
        #1;
        waited = 0;
        while (pop_m !== 1'b1 && waited < 300) begin
            cyc();
            #1;
            waited++;
        end
        chk("pop_seen", pop_m, 1'b1);
        if (last_pop >= 0) pop_gap = cycle_n - last_pop;
        last_pop = cycle_n;
        cyc();
        if (!hold) rdy_v = 1'b0;
        din_v = 18'($urandom);
    endtask

    task automatic send(input logic [17:0] w, input bit hold);
        int bd, nw, sv, bad_tx, bad_bsy, bad_pop, bad_done, got;
        int b[3];
        bit frame[30];
        bit dec[30];
        bit exp_done;
        bd = (sel != 0) ? 2 : 4;
        nw = (sel != 0) ? 1 : 3;
        sv = int'($signed(w));
        for (int j = 0; j < 3; j++) begin
            b[j] = (sv >>> (8 * j)) & 255;
            frame[10 * j] = 1'b0;
            for (int i = 0; i < 8; i++) frame[10 * j + 1 + i] = ((b[j] >> i) & 1) != 0;
            frame[10 * j + 9] = 1'b1;
        end
        start_word(w, hold);
        chk("tx_falls", tx_m, 1'b0);
        bad_tx = 0; bad_bsy = 0; bad_pop = 0; bad_done = 0;
        for (int k = 0; k < 30 * bd; k++) begin
            #1;
            if (tx_m !== frame[k / bd]) bad_tx++;
            if (bsy_m !== 1'b1) bad_bsy++;
            if (pop_m !== 1'b0) bad_pop++;
            if (done_m !== 1'b0) bad_done++;
            if (k % bd == bd / 2) dec[k / bd] = tx_m;
            cyc();
        end
        chk("frame_tx_bad_cycles", bad_tx, 0);
        chk("frame_bsy_bad_cycles", bad_bsy, 0);
        chk("frame_pop_bad_cycles", bad_pop, 0);
        chk("frame_done_bad_cycles", bad_done, 0);
        for (int j = 0; j < 3; j++) begin
            got = 0;
            for (int i = 0; i < 8; i++) got = got | (int'(dec[10 * j + 1 + i]) << i);
            chk($sformatf("byte%0d", j), got, b[j]);
        end
        words[sel]++;
        exp_done = (words[sel] % nw) == 0;
        #1;
        chk("end_tx", tx_m, 1'b1);
        chk("end_bsy", bsy_m, 1'b0);
        chk("end_done", done_m, 32'(exp_done));
        chk("end_pop", pop_m, 32'(rdy_v & ~exp_done));
        if (exp_done) begin
            cyc();
            #1;
            chk("after_done", done_m, 1'b0);
            chk("after_done_pop", pop_m, 32'(rdy_v));
        end
    endtask

    initial begin
        int bad_tx, bad_bsy, bad_pop, bad_done;
        sel = 0;
        rst_n = 1'b0;
        rdy_v = 1'b0;
        din_v = 18'd0;
        do_reset(2);

        bad_tx = 0; bad_bsy = 0; bad_pop = 0; bad_done = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            #1;
            if (tx_m !== 1'b1) bad_tx++;
            if (bsy_m !== 1'b0) bad_bsy++;
            if (pop_m !== 1'b0) bad_pop++;
            if (done_m !== 1'b0) bad_done++;
        end
        chk("idle_tx", bad_tx, 0);
        chk("idle_bsy", bad_bsy, 0);
        chk("idle_pop", bad_pop, 0);
        chk("idle_done", bad_done, 0);

        send(18'h12345, 1'b0);
        send(18'h3FFFE, 1'b0);
        send(18'($urandom), 1'b0);

        // Continuous rdy: pops 30*BAUD_DIV+1 apart, one extra cycle around tx_done.
        do_reset(1);
        last_pop = -1;
        send(18'h20001, 1'b1);
        send(18'h1FFFF, 1'b1);
        chk("gap_w2", pop_gap, 121);
        send(18'h2AA55, 1'b1);
        chk("gap_w3", pop_gap, 121);
        send(18'($urandom), 1'b1);
        chk("gap_after_done", pop_gap, 122);
        rdy_v = 1'b0;

        // Reset during DATA of byte1, then a fresh three-word image.
        start_word(18'h3C3C3, 1'b0);
        repeat (50) cyc();
        #1;
        chk("mid_bsy_before", bsy_m, 1'b1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        words[0] = 0;
        #1;
        chk("mid_rst_tx", tx_m, 1'b1);
        chk("mid_rst_bsy", bsy_m, 1'b0);
        chk("mid_rst_done", done_m, 1'b0);
        cyc();
        send(18'($urandom), 1'b0);
        send(18'($urandom), 1'b0);
        send(18'($urandom), 1'b0);

        // Second instance: one word per image, 60-cycle words.
        sel = 1;
        do_reset(1);
        last_pop = -1;
        send(18'($urandom), 1'b0);
        send(18'h20000, 1'b1);
        send(18'($urandom), 1'b1);
        chk("gap_b", pop_gap, 62);
        rdy_v = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l3_uart_tx.md
Name: l3_uart_tx

Overview:
- Drain-side consumer for the pooled-result buffer of layer 3.
- Pulls 18-bit signed words from the buffer using a rdy/pop handshake and serialises each one as three 8N1 UART bytes on TX.
- After NUM_WORDS words have been sent it pulses tx_done, which clears the producer's read and write pointers for the next image.

Parameters:
- BAUD_DIV, 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.
- NUM_WORDS, 98: words per image. Legal range is 1..128, held in a 7-bit word counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous and active-low.
- rdy  input  1  producer has at least one unread word.
- din  input  18  signed word from the producer; valid whenever rdy=1.
- pop  output  1  combinational one-cycle acknowledge; din is consumed at this clock edge.
- TX  output  1  UART serial line, idle high.
- bsy  output  1  high while a word is being serialised.
- tx_done  output  1  one-cycle pulse after the last stop bit of word NUM_WORDS.

Behaviour:
- Reset is synchronous. At a posedge with rst_n=0, all state is cleared and the block enters IDLE.
  - Reset values: TX=1, bsy=0, tx_done=0, word_cnt=0, byte_idx=0, baud_cnt=0, bit_cnt=0.
  - pop=0 while rst_n=0.
  - Reset mid-frame aborts the frame; TX is 1 in the cycle after the reset edge.
- State machine: IDLE, START, DATA, STOP.
  - IDLE:
    - TX=1, bsy=0.
    - pop = rdy & ~tx_done.
    - When pop=1: word_reg<=din, byte_idx<=0, baud_cnt<=0, next state START.
  - START:
    - TX=0 for BAUD_DIV cycles, then go to DATA with bit_cnt=0.
  - DATA:
    - TX = shift_reg[0] for BAUD_DIV cycles per bit; shift right after each bit.
    - After bit 7, go to STOP.
  - STOP:
    - TX=1 for BAUD_DIV cycles.
    - At the end of the stop bit, if byte_idx<2: byte_idx++, load the next byte, go to START. There is no idle gap between bytes.
    - If byte_idx=2: the word is complete; go to IDLE.
- Byte order is LSB byte first; within each byte, bits go LSB first.
  - byte0 = word_reg[7:0]
  - byte1 = word_reg[15:8]
  - byte2 = {6{word_reg[17]}, word_reg[17:16]} (sign-extended)
- bsy=1 in every state except IDLE, starting the cycle after the pop edge.
- baud_cnt counts 0..BAUD_DIV-1 and wraps; a bit advances when baud_cnt=BAUD_DIV-1.
- Latency:
  - TX falls in the first cycle after the pop edge.
  - One word occupies exactly 30*BAUD_DIV cycles of non-IDLE states.
  - Minimum spacing between pops is 30*BAUD_DIV+1 cycles.
- Word counting:
  - On word completion: if word_cnt==NUM_WORDS-1, then word_cnt<=0 and tx_done<=1 (registered). Otherwise word_cnt++.
  - tx_done is high for exactly the first IDLE cycle after the final word.
- Simultaneous events:
  - rdy=1 during the tx_done cycle gives pop=0; the producer is being cleared that cycle.
  - A pop may occur in the following cycle.
- rdy is ignored outside IDLE. pop is never asserted outside IDLE.
- din is sampled only at the pop edge; later changes to din do not affect the word in flight.
- If rdy deasserts mid-word, transmission continues unaffected.
- Byte payloads are not checked; no parity is generated.

Test Plan:
- BAUD_DIV=4, NUM_WORDS=3, reset then rdy=0 for 50 cycles -> TX=1, bsy=0, pop=0, tx_done=0 throughout.
- rdy=1, din=18'h12345 for one pop (pulse pop for 1 cycle with din, as the producer does, then rdy=0) -> pop high exactly 1 cycle; TX low the next cycle.
  - Decoded bytes 0x45, 0x23, 0x01.
  - bsy high for 120 cycles.
  - No tx_done.
- din=-2 (18'h3FFFE) -> decoded bytes 0xFE, 0xFF, 0xFF; each bit exactly 4 cycles; stop bits high.
- Hold rdy=1 continuously with 3 distinct words -> pops spaced exactly 121 cycles apart.
  - tx_done high 1 cycle after the 3rd word's stop bit.
  - pop=0 in that cycle, then a pop in the next cycle (word_cnt restarted at 0).
- Assert rst_n=0 for 1 cycle during DATA of byte1 -> TX=1, bsy=0 after the reset edge.
  - Next word transmits normally; word_cnt is back to 0, so tx_done only follows 3 further words.
- NUM_WORDS=1, BAUD_DIV=2 -> tx_done pulses after every word; each word takes 60 cycles.
